mul_sequencer: RTL
==================

// Module: mul_sequencer
// PURPOSE
//  Multi-cycle unsigned 16x16 multiplier that reuses the shared datapath ALU: it drives
//  AluOp/Op1/Op2 and captures Result each cycle, running shift-add over ADD, LSL and LSR.
//  It sits beside the ALU in the datapath. It owns the ALU operand bus only while Busy=1.
//  Outputs are the low WIDTH bits of the product and a sticky Overflow flag.
// PARAMETERS
//  WIDTH  16  operand/result width; equals ALU width; iteration count = WIDTH
// PORTS
//  Clock    in   1      single clock, rising edge
//  Reset    in   1      asynchronous, active-high
//  Start    in   1      request; sampled only in IDLE
//  A        in   WIDTH  multiplicand, captured on accepted Start
//  B        in   WIDTH  multiplier, captured on accepted Start
//  Busy     out  1      high from the cycle after Start acceptance through DONE
//  Done     out  1      one-cycle pulse; Product/Overflow valid
//  Product  out  WIDTH  low WIDTH bits of A*B; held until next accepted Start
//  Overflow out  1      true product exceeds WIDTH bits; held with Product
//  AluOp    out  opcodes::alu_functions_t  function to shared ALU
//  Op1      out  WIDTH  ALU operand 1
//  Op2      out  WIDTH  ALU operand 2
//  Result   in   WIDTH  ALU combinational result, sampled at the clock edge
// BEHAVIOUR
//  Reset (async, Reset=1): state IDLE, Busy=0, Done=0, Product=0, Overflow=0, internal
//   Acc/M/Q/Cnt=0, AluOp=FnMem, Op1=0, Op2=0. Reset mid-operation aborts; no Done.
//  States: IDLE, ADD, SHL, SHR, DONE. Each state lasts exactly one cycle, except IDLE.
//  IDLE: if Start -> Acc=0, M=A, Q=B, Cnt=0, Overflow=0, go to ADD. Else stay.
//  ADD: if Q[0]=1, AluOp=FnADD, Op1=Acc, Op2=M; if Q[0]=0, AluOp=FnMem, Op1=Acc.
//   Acc<=Result. Set Overflow if FnADD and Result<Acc (carry out). Go to SHL.
//  SHL: AluOp=FnLSL, Op1=M; M<=Result. Set Overflow if M[WIDTH-1]=1 and Q[WIDTH-1:1]!=0.
//   Go to SHR.
//  SHR: AluOp=FnLSR, Op1=Q; Q<=Result; Cnt<=Cnt+1. Go to DONE if Cnt==WIDTH-1 (or the
//   early-exit condition below holds); otherwise go to ADD.
//  DONE: Product<=Acc, Done=1 for this cycle, go to IDLE. Start is ignored in DONE.
//  In IDLE and DONE the sequencer drives AluOp=FnMem, Op1=0, Op2=0.
//  Op2 is 0 in every state except ADD.
//  Latency without early exit: Start accepted at edge 0 -> Done high during cycle 3*WIDTH+1
//   (49 for WIDTH=16). Earliest next Start acceptance is the cycle after DONE.
//  Start while Busy is ignored; it is neither queued nor acknowledged.
//  A/B may change after acceptance without affecting the operation.
//  Arithmetic is unsigned modulo 2^WIDTH. Cnt is $clog2(WIDTH)+1 bits and never wraps.
// CONFIGURATION
//  MUL_SEQUENCER_EARLY_EXIT_EN defined: in SHR, also go to DONE when Result==0 (remaining
//   multiplier is zero). Latency becomes 3*k+1, where k = index of B's highest set bit + 1;
//   B=0 gives k=1. Product and Overflow are unchanged.
//  Not defined: the sequencer always runs WIDTH iterations (fixed latency).
// STRUCTURE
//  Shared package opcodes: add mulseq_state_t (IDLE, ADD, SHL, SHR, DONE) and
//   MUL_WIDTH=16 next to alu_functions_t.
//  No sub-module: the ALU is instantiated once in the datapath, with a mux on its
//   operand bus selected by Busy. The bench instantiates alu + mul_sequencer back to back.
// TESTING
//  A=3, B=5, Start one cycle -> Busy next cycle; Done at cycle 49, Product=15, Overflow=0.
//  A=0xFFFF, B=0xFFFF -> Product=0x0001, Overflow=1. A=0x0100, B=0x0100 -> Product=0, Overflow=1.
//  A=0x1234, B=0 -> Product=0, Overflow=0. With EARLY_EXIT_EN, Done at cycle 4.
//  Start pulsed with A=9, B=9 at cycle 10 of a 3*5 run -> ignored; result 15, one Done only.
//  Reset at cycle 20 mid-run -> outputs at reset values at once; no Done; new 2*7 run -> 14.
//  EARLY_EXIT_EN with A=7, B=1 -> Done at cycle 4, Product=7. Random A/B vs a*b model.

Source files
------------

// File: rtl/mul_sequencer_pkg.sv
// Shared opcode/state definitions for the datapath, plus helpers for the
// shift-add multiply sequencer.
package opcodes;
   localparam int MUL_WIDTH = 16;

   // ALU function select; LSL/LSR shift Op1 by one bit position
   typedef enum logic [2:0] {
      FnMem, FnADD, FnSUB, FnAND, FnOR, FnXOR, FnLSL, FnLSR
   } alu_functions_t;

   // Multiply sequencer states
   typedef enum logic [2:0] {
      IDLE, ADD, SHL, SHR, DONE
   } mulseq_state_t;
endpackage

package mul_sequencer_pkg;
   // Iteration counter width: holds 0..WIDTH without wrapping
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction
endpackage

// File: rtl/mul_sequencer_if.sv
// Requester / ALU-bus interface of the multiply sequencer.
// slave  : the sequencer (owns AluOp/Op1/Op2 while Busy)
// master : datapath side (drives Start/A/B, returns ALU Result)
interface mul_sequencer_if
   import opcodes::*;
#(parameter int WIDTH = MUL_WIDTH);
   logic                 Start;
   logic [WIDTH-1:0]     A;
   logic [WIDTH-1:0]     B;
   logic                 Busy;
   logic                 Done;
   logic [WIDTH-1:0]     Product;
   logic                 Overflow;
   alu_functions_t       AluOp;
   logic [WIDTH-1:0]     Op1;
   logic [WIDTH-1:0]     Op2;
   logic [WIDTH-1:0]     Result;

   modport slave (
      input  Start, A, B, Result,
      output Busy, Done, Product, Overflow, AluOp, Op1, Op2
   );

   modport master (
      output Start, A, B, Result,
      input  Busy, Done, Product, Overflow, AluOp, Op1, Op2
   );
endinterface

// File: rtl/alu.sv
// Shared combinational datapath ALU. FnMem passes Op1 through unchanged,
// which the sequencer relies on to hold Acc on a skipped add.
module alu
   import opcodes::*;
#(parameter int WIDTH = MUL_WIDTH) (
   input  alu_functions_t   fn_i,
   input  logic [WIDTH-1:0] op1_i,
   input  logic [WIDTH-1:0] op2_i,
   output logic [WIDTH-1:0] result_o
);
   // function decode
   always_comb begin
      result_o = '0;
      case (fn_i)
         FnMem:   result_o = op1_i;
         FnADD:   result_o = op1_i + op2_i;
         FnSUB:   result_o = op1_i - op2_i;
         FnAND:   result_o = op1_i & op2_i;
         FnOR:    result_o = op1_i | op2_i;
         FnXOR:   result_o = op1_i ^ op2_i;
         FnLSL:   result_o = {op1_i[WIDTH-2:0], 1'b0};
         FnLSR:   result_o = {1'b0, op1_i[WIDTH-1:1]};
         default: result_o = '0;
      endcase
   end
endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle unsigned WIDTHxWIDTH multiplier that borrows the shared ALU:
// each iteration is ADD (conditional accumulate), SHL (multiplicand <<1),
// SHR (multiplier >>1). Product is the low WIDTH bits; Overflow is sticky
// for the operation and set whenever a product bit would leave WIDTH.
// Optional build macro: MUL_SEQUENCER_EARLY_EXIT_EN -- finish as soon as the
// remaining multiplier is zero (data-dependent latency, same results).
module mul_sequencer
   import opcodes::*;
   import mul_sequencer_pkg::*;
#(parameter int WIDTH = MUL_WIDTH) (
   input  logic           Clock,
   input  logic           Reset,
   mul_sequencer_if.slave bus
);
   localparam int CNT_W = cnt_width(WIDTH);

   mulseq_state_t    state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] prod_q, prod_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             last_iter;

   // end of multiply: all WIDTH bits consumed, or nothing left to add
   always_comb begin
      last_iter = (cnt_q == CNT_W'(WIDTH-1));
`ifdef MUL_SEQUENCER_EARLY_EXIT_EN
      if (bus.Result == '0) last_iter = 1'b1;
`endif
   end

   // state register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // next-state logic; Start only counts in IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.Start) state_d = ADD;
         ADD:     state_d = SHL;
         SHL:     state_d = SHR;
         SHR:     state_d = last_iter ? DONE : ADD;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ALU bus and status outputs per state
   always_comb begin
      bus.AluOp = FnMem;
      bus.Op1   = '0;
      bus.Op2   = '0;
      bus.Busy  = (state_q != IDLE);
      bus.Done  = (state_q == DONE);
      case (state_q)
         ADD: begin
            bus.Op1 = acc_q;
            if (q_q[0]) begin
               bus.AluOp = FnADD;
               bus.Op2   = m_q;
            end
         end
         SHL: begin
            bus.AluOp = FnLSL;
            bus.Op1   = m_q;
         end
         SHR: begin
            bus.AluOp = FnLSR;
            bus.Op1   = q_q;
         end
         default: ;
      endcase
   end

   // datapath next values captured from the ALU result
   always_comb begin
      acc_d  = acc_q;
      m_d    = m_q;
      q_d    = q_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      prod_d = prod_q;
      case (state_q)
         IDLE: if (bus.Start) begin
            acc_d = '0;
            m_d   = bus.A;
            q_d   = bus.B;
            cnt_d = '0;
            ovf_d = 1'b0;
         end
         ADD: begin
            acc_d = bus.Result;
            // sum wrapped below the old accumulator: carry out of WIDTH
            if (q_q[0] && (bus.Result < acc_q)) ovf_d = 1'b1;
         end
         SHL: begin
            m_d = bus.Result;
            // a multiplicand bit leaves WIDTH while multiplier bits still need it
            if (m_q[WIDTH-1] && (q_q[WIDTH-1:1] != '0)) ovf_d = 1'b1;
         end
         SHR: begin
            q_d   = bus.Result;
            cnt_d = cnt_q + CNT_W'(1);
         end
         DONE: prod_d = acc_q;
         default: ;
      endcase
   end

   // datapath registers
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         acc_q  <= '0;
         m_q    <= '0;
         q_q    <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         prod_q <= '0;
      end else begin
         acc_q  <= acc_d;
         m_q    <= m_d;
         q_q    <= q_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         prod_q <= prod_d;
      end
   end

   assign bus.Product  = prod_q;
   assign bus.Overflow = ovf_q;
endmodule
